// File: rtl/vec_result_collector_pkg.sv
// Shared definitions for the vector result collector: FSM encoding and
// lane piece width codes.
package vec_result_collector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_t;

  localparam logic [1:0] LW8  = 2'd0;
  localparam logic [1:0] LW16 = 2'd1;
  localparam logic [1:0] LW32 = 2'd2;
  localparam logic [1:0] LW64 = 2'd3;

  // Piece width in bits for a width code.
  function automatic logic [6:0] piece_width(input logic [1:0] lw);
    piece_width = 7'd8 << lw;
  endfunction

  // Byte-enable pattern of a piece placed at byte 0.
  function automatic logic [7:0] piece_byte_mask(input logic [1:0] lw);
    case (lw)
      LW8:     piece_byte_mask = 8'h01;
      LW16:    piece_byte_mask = 8'h03;
      LW32:    piece_byte_mask = 8'h0F;
      default: piece_byte_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/vec_result_collector_merge.sv
// Combinational merge of one lane result piece into the destination image.
// Illegal pieces (misaligned or overrunning VLEN) leave image and be untouched.
module vec_piece_merge
  import vec_result_collector_pkg::*;
#(
  parameter int VLEN = 128,
  parameter int IDXW = 10
) (
  input  logic [VLEN-1:0]   image,
  input  logic [VLEN/8-1:0] be,
  input  logic [63:0]       data,
  input  logic [IDXW-1:0]   index,
  input  logic [1:0]        lw,
  output logic [VLEN-1:0]   image_nxt,
  output logic [VLEN/8-1:0] be_nxt,
  output logic              legal
);

  localparam int BEW = VLEN / 8;

  logic [6:0]      w;
  logic [31:0]     end_bit;
  logic [63:0]     data_mask;
  logic [VLEN-1:0] data_sh;
  logic [VLEN-1:0] bit_mask;
  logic [BEW-1:0]  be_sh;

  always_comb begin
    w         = piece_width(lw);
    end_bit   = 32'(index) + 32'(w);
    legal     = (index[2:0] == 3'd0) &&
                ((32'(index) & (32'(w) - 32'd1)) == 32'd0) &&
                (end_bit <= 32'(VLEN));
    // A shift by 64 yields zero, so a 64-bit piece keeps every data bit.
    data_mask = ~(64'hFFFF_FFFF_FFFF_FFFF << w);
    data_sh   = VLEN'(data & data_mask) << index;
    be_sh     = BEW'(piece_byte_mask(lw)) << index[IDXW-1:3];
    bit_mask  = '0;
    for (int b = 0; b < BEW; b++) begin
      bit_mask[b*8 +: 8] = {8{be_sh[b]}};
    end
    image_nxt = image;
    be_nxt    = be;
    if (legal) begin
      image_nxt = (image & ~bit_mask) | data_sh;
      be_nxt    = be | be_sh;
    end
  end

endmodule

// File: rtl/vec_result_collector.sv
// Collects vector lane result pieces into one VLEN-bit image and commits it
// to the register file write port when the last piece arrives.
module vec_result_collector
  import vec_result_collector_pkg::*;
#(
  parameter int VLEN = 128,
  parameter int IDXW = 10
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [4:0]        vd_addr,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [63:0]       in_data,
  input  logic [IDXW-1:0]   in_index,
  input  logic [1:0]        in_lw,
  input  logic              in_last,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [4:0]        wr_addr,
  output logic [VLEN-1:0]   wr_data,
  output logic [VLEN/8-1:0] wr_be,
  output logic              done,
  output logic              err,
  output state_t            dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both 1; in_ready/wr_valid depend only on state, never on the peer.

  state_t            state_q, state_d;
  logic [4:0]        addr_q;
  logic [VLEN-1:0]   image_q;
  logic [VLEN/8-1:0] be_q;
  logic              err_q;
  logic              done_q;

  logic [VLEN-1:0]   image_nxt;
  logic [VLEN/8-1:0] be_nxt;
  logic              legal;
  logic              open_go;
  logic              beat_go;
  logic              commit_go;

  vec_piece_merge #(.VLEN(VLEN), .IDXW(IDXW)) u_merge (
    .image     (image_q),
    .be        (be_q),
    .data      (in_data),
    .index     (in_index),
    .lw        (in_lw),
    .image_nxt (image_nxt),
    .be_nxt    (be_nxt),
    .legal     (legal)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    wr_valid  = 1'b0;
    open_go   = 1'b0;
    beat_go   = 1'b0;
    commit_go = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          open_go = 1'b1;
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        in_ready = 1'b1;
        // Abort discards any beat handshaken in the same cycle.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (in_valid) begin
          beat_go = 1'b1;
          if (in_last) state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        wr_valid = 1'b1;
        if (wr_ready) begin
          commit_go = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_q  <= '0;
      image_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= commit_go;
      if (open_go) begin
        addr_q  <= vd_addr;
        image_q <= '0;
        be_q    <= '0;
        err_q   <= 1'b0;
      end else if (beat_go) begin
        if (legal) begin
          image_q <= image_nxt;
          be_q    <= be_nxt;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign wr_addr   = addr_q;
  assign wr_data   = image_q;
  assign wr_be     = be_q;
  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_vec_result_collector.sv
// Directed bench for vec_result_collector (VLEN=128): fills, backpressure,
// illegal pieces, abort and reset during commit.
module tb_vec_result_collector;
  import vec_result_collector_pkg::*;

  localparam int VLEN = 128;
  localparam int IDXW = 10;

  logic              clk = 1'b0;
  logic              resetn;
  logic              start;
  logic [4:0]        vd_addr;
  logic              abort;
  logic              in_valid;
  logic              in_ready;
  logic [63:0]       in_data;
  logic [IDXW-1:0]   in_index;
  logic [1:0]        in_lw;
  logic              in_last;
  logic              wr_valid;
  logic              wr_ready;
  logic [4:0]        wr_addr;
  logic [VLEN-1:0]   wr_data;
  logic [VLEN/8-1:0] wr_be;
  logic              done;
  logic              err;
  state_t            dbg_state;

  int total = 0;
  int bad   = 0;

  vec_result_collector #(.VLEN(VLEN), .IDXW(IDXW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .vd_addr   (vd_addr),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_index  (in_index),
    .in_lw     (in_lw),
    .in_last   (in_last),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_be     (wr_be),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [1:0] lw, input int idx, input logic [63:0] d, input logic last);
    in_valid = 1'b1;
    in_lw    = lw;
    in_index = IDXW'(idx);
    in_data  = d;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic open_coll(input logic [4:0] a);
    start   = 1'b1;
    vd_addr = a;
    step();
    start   = 1'b0;
  endtask

  logic [VLEN-1:0] exp_data;

  initial begin
    resetn = 1'b0; start = 1'b0; vd_addr = '0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0; in_index = '0; in_lw = '0; in_last = 1'b0;
    wr_ready = 1'b0;
    step(); step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_addr",  wr_addr, 0);
    chk("rst_wr_data",  wr_data, 0);
    chk("rst_wr_be",    wr_be, 0);
    chk("rst_done",     done, 0);
    chk("rst_err",      err, 0);
    resetn = 1'b1;
    step();

    // start together with abort: abort wins
    start = 1'b1; abort = 1'b1; vd_addr = 5'd9;
    step();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", in_ready, 0);

    // full 8-bit fill
    open_coll(5'd5);
    chk("t1_in_ready", in_ready, 1);
    exp_data = '0;
    for (int i = 0; i < 16; i++) begin
      exp_data[8*i +: 8] = 8'(8'h10 + i);
      beat(LW8, 8*i, 64'hFFFF_FFFF_FFFF_FF00 | 64'(8'h10 + i), i == 15);
    end
    chk("t1_wr_valid", wr_valid, 1);
    chk("t1_in_ready", in_ready, 0);
    chk("t1_wr_addr",  wr_addr, 5);
    chk("t1_wr_be",    wr_be, 16'hFFFF);
    chk("t1_wr_data",  wr_data, exp_data);
    chk("t1_done_pre", done, 0);
    wr_ready = 1'b1;
    step();
    wr_ready = 1'b0;
    chk("t1_done",       done, 1);
    chk("t1_wr_valid_0", wr_valid, 0);
    step();
    chk("t1_done_pulse", done, 0);

    // partial 32-bit fill with commit backpressure
    open_coll(5'd12);
    beat(LW32, 0,  64'hDEAD_BEEF_AABB_CCDD, 1'b0);
    beat(LW32, 64, 64'h1122_3344, 1'b1);
    exp_data = {32'h0, 32'h1122_3344, 32'h0, 32'hAABB_CCDD};
    chk("t2_wr_be",   wr_be, 16'h0F0F);
    chk("t2_wr_data", wr_data, exp_data);
    chk("t2_err",     err, 0);
    chk("t2_wr_addr", wr_addr, 12);
    abort = 1'b1; start = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_wr_valid", wr_valid, 1);
      chk("bp_wr_data",  wr_data, exp_data);
      chk("bp_wr_be",    wr_be, 16'h0F0F);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_done",     done, 0);
    end
    abort = 1'b0; start = 1'b0; in_valid = 1'b0;
    wr_ready = 1'b1;
    step();
    wr_ready = 1'b0;
    chk("t2_done", done, 1);

    // illegal pieces
    open_coll(5'd3);
    beat(LW64, 96, 64'h0123_4567_89AB_CDEF, 1'b0);
    chk("t3_err_overrun", err, 1);
    beat(LW16, 8, 64'hBEEF, 1'b0);
    beat(LW8, 0, 64'h5A, 1'b1);
    chk("t3_err",     err, 1);
    chk("t3_wr_be",   wr_be, 16'h0001);
    chk("t3_wr_data", wr_data, 128'h5A);
    wr_ready = 1'b1;
    step();
    wr_ready = 1'b0;
    chk("t3_done", done, 1);

    // next start clears err; then abort after 3 beats
    open_coll(5'd7);
    chk("t4_err_clear", err, 0);
    beat(LW8, 0,  64'hA1, 1'b0);
    beat(LW8, 8,  64'hA2, 1'b0);
    beat(LW8, 16, 64'hA3, 1'b0);
    abort = 1'b1;
    in_valid = 1'b1; in_lw = LW8; in_index = IDXW'(24); in_data = 64'hA4; in_last = 1'b1;
    step();
    abort = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    chk("ab_in_ready", in_ready, 0);
    chk("ab_wr_valid", wr_valid, 0);
    chk("ab_done",     done, 0);
    step();
    chk("ab_wr_valid2", wr_valid, 0);
    chk("ab_done2",     done, 0);

    // reset during COMMIT
    open_coll(5'd21);
    beat(LW8, 32, 64'h77, 1'b1);
    chk("rc_wr_valid", wr_valid, 1);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("rc_wr_valid0", wr_valid, 0);
    chk("rc_in_ready0", in_ready, 0);
    chk("rc_wr_addr0",  wr_addr, 0);
    chk("rc_wr_data0",  wr_data, 0);
    chk("rc_wr_be0",    wr_be, 0);
    chk("rc_done0",     done, 0);
    chk("rc_err0",      err, 0);

    // no stale bytes or enables afterwards
    open_coll(5'd30);
    beat(LW8, 8, 64'h99, 1'b1);
    chk("st_wr_be",   wr_be, 16'h0002);
    chk("st_wr_data", wr_data, 128'h9900);
    chk("st_wr_addr", wr_addr, 30);
    wr_ready = 1'b1;
    step();
    wr_ready = 1'b0;
    chk("st_done", done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
